// File: rtl/sub32_seq.sv
// sub32_seq: sequential 32-bit subtractor (a - b) that processes CHUNK bits
// per clock cycle and uses a valid/ready handshake on both sides.
//
// Parameters
//   CHUNK      : bits processed per cycle (1, 2, 4, 8, 16 or 32); N = 32/CHUNK
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : a/b are valid
//   in_ready   : block is idle and can take operands
//   a, b       : minuend, subtrahend
//   out_valid  : result is valid (held until out_ready)
//   out_ready  : consumer takes the result
//   out        : a - b modulo 2^32
//   out_c      : borrow out of bit 31 (a < b unsigned)
//   out_flower : signed overflow
//   out_zero   : out == 0 (only when SUB32_ZERO_FLAG_EN is defined)
//
// Optional feature macro: SUB32_ZERO_FLAG_EN
module sub32_seq #(
  parameter int unsigned CHUNK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        out_c,
  output logic        out_flower
`ifdef SUB32_ZERO_FLAG_EN
  ,
  output logic        out_zero
`endif
);

  localparam int unsigned W     = 32;
  localparam int unsigned N     = W / CHUNK;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW1   = CHUNK + 1;
  localparam logic [W-1:0] CHUNK_MASK = W'((64'(1) << CHUNK) - 64'(1));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, b_q;
  logic [CNT_W-1:0] cnt_q;
  logic             borrow_q;
  logic [W-1:0]     res_q;
  logic [W-1:0]     out_q;
  logic             out_c_q;
  logic             flower_q;
  logic             in_ready_q;
  logic             out_valid_q;
`ifdef SUB32_ZERO_FLAG_EN
  logic             zero_q;
`endif

  logic [4:0]       base_c;
  logic [CHUNK-1:0] a_ch_c, b_ch_c;
  logic [CW1-1:0]   diff_c;
  logic [W-1:0]     res_d_c;
  logic             last_c;

  // Chunk datapath: select current chunk, subtract with borrow, merge into result
  always_comb begin
    base_c  = 5'(32'(cnt_q) * CHUNK);
    a_ch_c  = CHUNK'(a_q >> base_c);
    b_ch_c  = CHUNK'(b_q >> base_c);
    // Top bit of the (CHUNK+1)-bit difference is the chunk borrow out
    diff_c  = {1'b0, a_ch_c} - {1'b0, b_ch_c} - CW1'(borrow_q);
    res_d_c = (res_q & ~(CHUNK_MASK << base_c)) |
              (W'(diff_c[CHUNK-1:0]) << base_c);
    last_c  = (cnt_q == CNT_W'(N - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)  state_d = S_BUSY;
      S_BUSY:  if (last_c)    state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Handshake flags registered from the next state so they track state_q
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_DONE);
    end
  end

  // Operand capture, chunk iteration and result publication
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      res_q    <= '0;
      out_q    <= '0;
      out_c_q  <= 1'b0;
      flower_q <= 1'b0;
`ifdef SUB32_ZERO_FLAG_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
          end
        end
        S_BUSY: begin
          res_q    <= res_d_c;
          borrow_q <= diff_c[CHUNK];
          cnt_q    <= cnt_q + CNT_W'(1);
          // Result registers only change on DONE entry, so they stay
          // stable through DONE and idle until the next result
          if (last_c) begin
            out_q    <= res_d_c;
            out_c_q  <= diff_c[CHUNK];
            flower_q <= (a_q[W-1] != b_q[W-1]) && (res_d_c[W-1] != a_q[W-1]);
`ifdef SUB32_ZERO_FLAG_EN
            zero_q   <= (res_d_c == '0);
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out        = out_q;
  assign out_c      = out_c_q;
  assign out_flower = flower_q;
`ifdef SUB32_ZERO_FLAG_EN
  assign out_zero   = zero_q;
`endif

endmodule
